// File: rtl/data_pkg.sv
// Shared definitions for the data_gen / data_check stream pattern pair.
// Holds the LFSR constants so generator-side and checker-side stalls stay identical.
package data_pkg;

    // Right-shifting Fibonacci LFSR, x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef struct packed {
        logic keep;
        logic last;
        logic seq;
        logic lane;
    } err_flags_t;

    typedef enum logic {
        SEED,
        RUN
    } chk_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s, input logic [15:0] taps);
        return {^(s & taps), s[15:1]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit free-running LFSR with load-on-reset seed and step enable.
// Used for pseudo-random TREADY/TVALID throttling.
module lfsr16
    import data_pkg::*;
#(
    parameter logic [15:0] SEED_VAL = LFSR_SEED,
    parameter logic [15:0] TAPS_VAL = LFSR_TAPS
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_en,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= SEED_VAL;
        end else if (i_en) begin
            r_state <= lfsr_next(r_state, TAPS_VAL);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/data_check.sv
// AXI-Stream checker for the replicated-counter pattern from data_gen.
// Stage 1 registers per-beat check results; stage 2 updates statistics and first-error capture.
module data_check
    import data_pkg::*;
#(
    parameter int unsigned DW        = 512,
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned PKT_BEATS = 8,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DW-1:0]     AXIS_IN_TDATA,
    input  logic [DW/8-1:0]   AXIS_IN_TKEEP,
    input  logic              AXIS_IN_TLAST,
    input  logic              AXIS_IN_TVALID,
    output logic              AXIS_IN_TREADY,
    input  logic              stall_en,
    input  logic              clear,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  beat_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              error,
    output logic [3:0]        err_flags,
    output logic [WORD_W-1:0] err_expect,
    output logic [WORD_W-1:0] err_actual
);

    localparam int unsigned LANES = DW / WORD_W;
    localparam int unsigned POS_W = $clog2(PKT_BEATS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [15:0]       w_lfsr;
    logic              w_accept;
    logic [WORD_W-1:0] w_w0;
    logic [LANES-1:0]  w_lane_neq;
    logic              w_last_pos;
    err_flags_t        w_flags;

    logic              r_tready;
    chk_state_e        r_state;
    logic [WORD_W-1:0] r_expect;
    logic [POS_W-1:0]  r_pos;

    logic              r_s1_vld;
    logic              r_s1_last;
    err_flags_t        r_s1_flags;
    logic [WORD_W-1:0] r_s1_expect;
    logic [WORD_W-1:0] r_s1_actual;

    logic [CNT_W-1:0]  r_pkt_cnt;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_error;
    err_flags_t        r_err_flags;
    logic [WORD_W-1:0] r_err_expect;
    logic [WORD_W-1:0] r_err_actual;

    lfsr16 #(
        .SEED_VAL (LFSR_SEED),
        .TAPS_VAL (LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk),
        .resetn  (resetn),
        .i_en    (1'b1),
        .o_state (w_lfsr)
    );

    assign w_accept   = AXIS_IN_TVALID & r_tready;
    assign w_w0       = AXIS_IN_TDATA[WORD_W-1:0];
    assign w_last_pos = (r_pos == POS_W'(PKT_BEATS - 1));

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_lane_neq[g] = (AXIS_IN_TDATA[g*WORD_W +: WORD_W] != w_w0);
    end

    always_comb begin
        w_flags      = '0;
        w_flags.keep = ~&AXIS_IN_TKEEP;
        w_flags.last = AXIS_IN_TLAST != w_last_pos;
        w_flags.seq  = (r_state == RUN) && (w_w0 != r_expect);
        w_flags.lane = |w_lane_neq;
    end

    // Acceptance stage: sequence tracking and per-beat check results.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tready    <= 1'b0;
            r_state     <= SEED;
            r_expect    <= '0;
            r_pos       <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_flags  <= '0;
            r_s1_expect <= '0;
            r_s1_actual <= '0;
        end else begin
            r_tready <= stall_en ? w_lfsr[0] : 1'b1;
            r_s1_vld <= w_accept && !clear;
            if (w_accept) begin
                // An accepted TLAST realigns packet position even when it arrived early.
                r_pos       <= (AXIS_IN_TLAST || w_last_pos) ? '0 : r_pos + 1'b1;
                r_s1_last   <= AXIS_IN_TLAST;
                r_s1_flags  <= w_flags;
                r_s1_expect <= r_expect;
                r_s1_actual <= w_w0;
                if (clear) begin
                    r_state <= SEED;
                end else begin
                    r_state  <= RUN;
                    r_expect <= w_w0 + 1'b1;
                end
            end else if (clear) begin
                r_state <= SEED;
            end
        end
    end

    // Statistics stage; clear wins over a result arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            r_pkt_cnt    <= '0;
            r_beat_cnt   <= '0;
            r_err_cnt    <= '0;
            r_error      <= 1'b0;
            r_err_flags  <= '0;
            r_err_expect <= '0;
            r_err_actual <= '0;
        end else if (r_s1_vld) begin
            r_beat_cnt <= sat_inc(r_beat_cnt);
            if (r_s1_last) begin
                r_pkt_cnt <= sat_inc(r_pkt_cnt);
            end
            if (|r_s1_flags) begin
                r_err_cnt <= sat_inc(r_err_cnt);
                r_error   <= 1'b1;
                if (!r_error) begin
                    r_err_flags  <= r_s1_flags;
                    r_err_expect <= r_s1_expect;
                    r_err_actual <= r_s1_actual;
                end
            end
        end
    end

    assign AXIS_IN_TREADY = r_tready;
    assign pkt_count      = r_pkt_cnt;
    assign beat_count     = r_beat_cnt;
    assign err_count      = r_err_cnt;
    assign error          = r_error;
    assign err_flags      = r_err_flags;
    assign err_expect     = r_err_expect;
    assign err_actual     = r_err_actual;

endmodule

// File: tb/tb_data_check.sv
// Randomized scoreboard bench for data_check: reference model pushes expected statistics
// per accepted beat; a monitor pops them when the DUT's counters reflect that beat.
module tb_data_check;

    localparam int unsigned DW        = 512;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned PKT_BEATS = 8;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned LANES     = DW / WORD_W;
    localparam int unsigned KW        = DW / 8;
    localparam int unsigned CNT_MAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              resetn;
    logic [DW-1:0]     tdata;
    logic [KW-1:0]     tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;
    logic              stall_en;
    logic              clear;
    logic [CNT_W-1:0]  pkt_count;
    logic [CNT_W-1:0]  beat_count;
    logic [CNT_W-1:0]  err_count;
    logic              error;
    logic [3:0]        err_flags;
    logic [WORD_W-1:0] err_expect;
    logic [WORD_W-1:0] err_actual;

    always #5 clk = ~clk;

    data_check #(
        .DW        (DW),
        .WORD_W    (WORD_W),
        .PKT_BEATS (PKT_BEATS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .AXIS_IN_TDATA  (tdata),
        .AXIS_IN_TKEEP  (tkeep),
        .AXIS_IN_TLAST  (tlast),
        .AXIS_IN_TVALID (tvalid),
        .AXIS_IN_TREADY (tready),
        .stall_en       (stall_en),
        .clear          (clear),
        .pkt_count      (pkt_count),
        .beat_count     (beat_count),
        .err_count      (err_count),
        .error          (error),
        .err_flags      (err_flags),
        .err_expect     (err_expect),
        .err_actual     (err_actual)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    typedef struct {
        int unsigned beats;
        int unsigned pkts;
        int unsigned errs;
        bit          err;
        int unsigned flags;
        int unsigned eexp;
        int unsigned eact;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    bit          m_seeded;
    int unsigned m_exp, m_pos, m_beats, m_pkts, m_errs, m_flags, m_eexp, m_eact;
    bit          m_err;

    function automatic void model_clear();
        m_beats = 0; m_pkts = 0; m_errs = 0; m_err = 0;
        m_flags = 0; m_eexp = 0; m_eact = 0; m_seeded = 0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_exp = 0;
        m_pos = 0;
    endfunction

    function automatic void model_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                       input bit last, input bit clr);
        int unsigned w0 = int'(d[WORD_W-1:0]);
        bit lane = 0, seq, lst, kp;
        exp_t e;
        for (int l = 1; l < LANES; l++)
            if (int'(d[l*WORD_W +: WORD_W]) != w0) lane = 1;
        seq = m_seeded && (w0 != m_exp);
        lst = last != (m_pos == PKT_BEATS - 1);
        kp  = (k != {KW{1'b1}});
        if (clr) begin
            model_clear();
        end else begin
            if (m_beats < CNT_MAX) m_beats++;
            if (last && m_pkts < CNT_MAX) m_pkts++;
            if (lane || seq || lst || kp) begin
                if (m_errs < CNT_MAX) m_errs++;
                if (!m_err) begin
                    m_flags = {kp, lst, seq, lane};
                    m_eexp  = m_exp;
                    m_eact  = w0;
                end
                m_err = 1;
            end
            m_seeded = 1;
            m_exp    = (w0 + 1) % (1 << WORD_W);
        end
        m_pos = last ? 0 : (m_pos + 1) % PKT_BEATS;
        e = '{m_beats, m_pkts, m_errs, m_err, m_flags, m_eexp, m_eact};
        sb_q.push_back(e);
    endfunction

    // Callers are always positioned 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                              input bit last, input bit clr);
        bit acc = 0;
        tdata  = d;
        tkeep  = k;
        tlast  = last;
        tvalid = 1'b1;
        clear  = clr;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (tready) begin
                acc = 1;
                break;
            end
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept_timeout: tready stayed 0, required 1 within 64 cycles");
        end else begin
            model_beat(d, k, last, clr);
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        clear  = 1'b0;
    endtask

    int unsigned g_idx;
    logic [15:0] g_word;

    task automatic gen_beat(input logic [15:0] w, input int bad_lane, input bit bad_keep,
                            input bit flip_last, input bit clr);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        bit last;
        for (int l = 0; l < LANES; l++) d[l*WORD_W +: WORD_W] = w;
        if (bad_lane >= 0) d[bad_lane*WORD_W +: WORD_W] = w ^ 16'h0100;
        k = {KW{1'b1}};
        if (bad_keep) k[$urandom_range(0, KW - 1)] = 1'b0;
        last  = (g_idx == PKT_BEATS - 1) ^ flip_last;
        g_idx = last ? 0 : g_idx + 1;
        drive_beat(d, k, last, clr);
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            gen_beat(g_word, -1, 0, 0, 0);
            g_word = g_word + 16'd1;
            idle($urandom_range(0, 1));
        end
    endtask

    task automatic do_clear();
        idle(3);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        model_clear();
    endtask

    // Monitor: counters reflect an accepted beat two falling edges after the accepting one.
    bit mon_p1 = 0, mon_p2 = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_p2) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got empty queue, required an entry");
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_count", beat_count, e.beats);
                    chk("pkt_count", pkt_count, e.pkts);
                    chk("err_count", err_count, e.errs);
                    chk("error", error, e.err);
                    chk("err_flags", err_flags, e.flags);
                    chk("err_expect", err_expect, e.eexp);
                    chk("err_actual", err_actual, e.eact);
                end
            end
            mon_p2 = mon_p1;
            mon_p1 = tvalid & tready & resetn;
        end
    end

    // TREADY against an independent model of the x^16+x^14+x^13+x^11 sequence.
    bit          lfsr_chk = 0;
    logic [15:0] m_lfsr;
    int          n_rdy0 = 0, n_rdy1 = 0;
    initial begin
        logic fb;
        forever begin
            @(negedge clk);
            if (lfsr_chk) begin
                chk("tready_lfsr", tready, m_lfsr[0]);
                if (tready) n_rdy1++; else n_rdy0++;
                fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
                m_lfsr = (m_lfsr >> 1) | (16'(fb) << 15);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tready"}, tready, 0);
        chk({tag, "_pkt"}, pkt_count, 0);
        chk({tag, "_beat"}, beat_count, 0);
        chk({tag, "_errc"}, err_count, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_flags"}, err_flags, 0);
        chk({tag, "_expect"}, err_expect, 0);
        chk({tag, "_actual"}, err_actual, 0);
    endtask

    initial begin
        int r;
        resetn = 0; stall_en = 0; clear = 0; tvalid = 0; tlast = 0;
        tdata = '0; tkeep = '1;
        model_reset();
        g_idx = 0;
        idle(3);
        chk_all_zero("reset");
        resetn = 1;
        @(negedge clk);
        chk("tready_pre_rise", tready, 0);
        @(negedge clk);
        chk("tready_rise", tready, 1);
        @(posedge clk); #1;

        // Clean generator stream, no stall
        g_word = 16'($urandom);
        stream(96);
        idle(3);
        chk("t1_beats", beat_count, 96);
        chk("t1_pkts", pkt_count, 12);
        chk("t1_errc", err_count, 0);

        // Reset with stall enabled, long stream saturating the 8-bit counters
        resetn = 0; stall_en = 1;
        idle(2);
        model_reset();
        g_idx  = 0;
        resetn = 1;
        @(negedge clk);
        chk("t2_tready_reset_low", tready, 0);
        @(posedge clk); #1;
        m_lfsr   = 16'hACE1;
        lfsr_chk = 1;
        stream(400);
        idle(3);
        lfsr_chk = 0;
        stall_en = 0;
        chk("t2_beat_sat", beat_count, CNT_MAX);
        chk("t2_pkts", pkt_count, 50);
        chk("t2_errc", err_count, 0);
        chk("t2_tready_seen_low", n_rdy0 > 0, 1);
        chk("t2_tready_seen_high", n_rdy1 > 0, 1);
        idle(2);

        // Sequence slip 0..5,7..
        do_clear();
        for (int i = 0; i < 20; i++) begin
            if (i != 6) gen_beat(16'(i), -1, 0, 0, 0);
        end
        idle(3);
        chk("t3_errc", err_count, 1);
        chk("t3_flags", err_flags, 4'b0010);
        chk("t3_expect", err_expect, 6);
        chk("t3_actual", err_actual, 7);

        // Lane 17 corrupted on beat 3
        do_clear();
        g_word = 16'($urandom);
        for (int i = 0; i < 16; i++) begin
            gen_beat(g_word, (i == 3) ? 17 : -1, 0, 0, 0);
            g_word = g_word + 16'd1;
        end
        idle(3);
        chk("t4_flags", err_flags, 4'b0001);
        chk("t4_errc", err_count, 1);

        // Early TLAST on beat 5, then realigned 8-beat packets
        do_clear();
        while (g_idx != 0) stream(1);
        for (int i = 0; i < 29; i++) begin
            gen_beat(g_word, -1, 0, (i == 4), 0);
            g_word = g_word + 16'd1;
        end
        idle(3);
        chk("t5_errc", err_count, 1);
        chk("t5_flags", err_flags, 4'b0100);

        // Counter wrap, then clear coincident with a beat and a reseed
        do_clear();
        g_word = 16'hFFFE;
        stream(4);
        idle(3);
        chk("t6_wrap_error", error, 0);
        gen_beat(g_word, -1, 0, 0, 1);
        idle(3);
        chk("t6_clear_beats", beat_count, 0);
        g_word = 16'h1234;
        stream(5);
        idle(3);
        chk("t6_reseed_error", error, 0);
        chk("t6_reseed_beats", beat_count, 5);

        // Random fault injection
        do_clear();
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            if (r >= 8 && r < 11) g_word = g_word + 16'($urandom_range(1, 5));
            gen_beat(g_word, (r < 5) ? $urandom_range(1, LANES - 1) : -1,
                     (r >= 5 && r < 8), (r >= 11 && r < 13), 0);
            g_word = g_word + 16'd1;
            idle($urandom_range(0, 1));
        end

        // Mid-operation reset with a beat presented
        idle(3);
        tdata  = '1;
        tvalid = 1;
        resetn = 0;
        idle(2);
        chk_all_zero("midreset");
        tvalid = 0;
        resetn = 1;
        model_reset();
        g_idx = 0;
        idle(2);
        stream(10);

        idle(5);
        chk("scoreboard_drain", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
